// File: rtl/rom_read_arbiter.sv
// Round-robin sharing of one synchronous-read ROM port among NUM_REQ requesters.
// Results return in issue order, tagged by requester ID, through a 2-entry response FIFO.
module rom_read_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned ID_BITS   = 2,
   parameter int unsigned WIDTH     = 1,
   parameter int unsigned ADDR_BITS = 9
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*ADDR_BITS-1:0] req_addr,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         rom_rd,
   output logic [ADDR_BITS-1:0]         rom_idx,
   input  logic [WIDTH-1:0]             rom_dout,
   output logic                         resp_valid,
   output logic [ID_BITS-1:0]           resp_id,
   output logic [WIDTH-1:0]             resp_data,
   input  logic                         resp_ready
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]     rr_ptr;
   logic [PTR_W-1:0]     grant;
   logic [PTR_W-1:0]     cand;
   logic                 found;
   logic                 issue;
   logic                 pop;
   logic [2:0]           occ_next;
   logic [ADDR_BITS-1:0] idx_q;
   logic [ADDR_BITS-1:0] addr_arr [NUM_REQ];

   logic                 p1_valid;
   logic [ID_BITS-1:0]   p1_id;

   logic [1:0]           fifo_count;
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [ID_BITS-1:0]   fifo_id   [2];
   logic [WIDTH-1:0]     fifo_data [2];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
      assign addr_arr[g] = req_addr[g*ADDR_BITS +: ADDR_BITS];
   end

   // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      found = 1'b0;
      grant = '0;
      cand  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            grant = cand;
         end
      end
   end

   // Credit check counts the same-cycle pop so a draining FIFO keeps full throughput
   always_comb begin
      pop       = resp_valid & resp_ready;
      occ_next  = 3'(fifo_count) + 3'(p1_valid) - 3'(pop);
      issue     = !rst && found && (occ_next <= 3'd1);
      req_ready = issue ? (NUM_REQ'(1) << grant) : '0;
      rom_rd    = issue;
      rom_idx   = issue ? addr_arr[grant] : idx_q;
   end

   assign resp_valid = (fifo_count != 2'd0);
   assign resp_id    = fifo_id[rd_ptr];
   assign resp_data  = fifo_data[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr     <= '0;
         idx_q      <= '0;
         p1_valid   <= 1'b0;
         p1_id      <= '0;
         fifo_count <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         for (int e = 0; e < 2; e++) begin
            fifo_id[e]   <= '0;
            fifo_data[e] <= '0;
         end
      end else begin
         idx_q    <= rom_idx;
         p1_valid <= issue;
         if (issue) begin
            rr_ptr <= PTR_W'((32'(grant) + 32'd1) % NUM_REQ);
            p1_id  <= ID_BITS'(grant);
         end
         // Capture stage: ROM data for last cycle's issue lands in the FIFO
         if (p1_valid) begin
            fifo_id[wr_ptr]   <= p1_id;
            fifo_data[wr_ptr] <= rom_dout;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         fifo_count <= fifo_count + 2'(p1_valid) - 2'(pop);
      end
   end

endmodule

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Shares one synchronous-read ROM port among NUM_REQ requesters. Each cycle a round-robin arbiter grants at most one pending request and drives the ROM index. It tracks the one-cycle ROM read latency and returns each result, tagged with the requester ID, through a 2-entry response FIFO with valid/ready backpressure. It sits between ROM clients (routing/config lookups) and the ROM primitive, and is the only driver of the ROM's Rd/IdxR.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ID_BITS, 2, requester ID width; must satisfy 2^ID_BITS ≥ NUM_REQ
- WIDTH, 1, ROM data width
- ADDR_BITS, 9, ROM address width

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request pending
- req_addr  in  NUM_REQ*ADDR_BITS  request address; requester i occupies bits [i*ADDR_BITS +: ADDR_BITS]
- req_ready  out  NUM_REQ  one-hot accept; request i is taken on a cycle where req_valid[i] and req_ready[i] are both high
- rom_rd  out  1  to ROM Rd; high on an issue cycle
- rom_idx  out  ADDR_BITS  to ROM IdxR
- rom_dout  in  WIDTH  from ROM DoutR; registered, valid the cycle after issue
- resp_valid  out  1  response available at FIFO head
- resp_id  out  ID_BITS  requester index of the head response
- resp_data  out  WIDTH  ROM data of the head response
- resp_ready  in  1  consumer accepts the head response

## Operation
- Requester contract: hold req_valid and req_addr stable until req_ready. Dropping req_valid before acceptance is legal; nothing is issued for it.
- Arbitration: round robin with pointer rr_ptr (reset 0). Grant the first i with req_valid[i] set, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - On an issue, rr_ptr ← (granted index + 1) mod NUM_REQ.
  - rr_ptr is unchanged on cycles with no issue.
- Issue condition (can_issue): occ_next ≤ 1, where occ_next = fifo_count + p1_valid − pop and pop = resp_valid & resp_ready.
- On an issue cycle:
  - req_ready is one-hot at the granted index.
  - rom_rd = 1 and rom_idx = req_addr of the granted requester.
  - Next cycle: p1_valid ← 1, p1_id ← granted index.
- No issue: req_ready = 0 and rom_rd = 0. rom_idx holds its last value, so no combinational path from the next requester is exposed.
- Capture stage: when p1_valid = 1, push {p1_id, rom_dout} into the FIFO at the end of that cycle. The credit rule guarantees space, so a push never finds the FIFO full.
- Response FIFO:
  - 2 entries, fifo_count 0..2.
  - Push and pop in the same cycle is allowed; count is unchanged.
  - The head is driven from a register; resp_valid = (fifo_count ≠ 0).
- Order: responses return in issue order, globally across all requesters.
- Reset, including mid-operation: rr_ptr, fifo_count, read/write pointers and p1_valid all clear. An in-flight ROM read is discarded; its data never reaches the FIFO.

## Timing
- Reset values:
  - req_ready = 0, rom_rd = 0, rom_idx = 0
  - resp_valid = 0, resp_id = 0, resp_data = 0
  - Outputs are valid from the first cycle after rst is sampled low.
- Latency: request accepted in cycle t → rom_rd in cycle t (same cycle) → rom_dout valid in t+1 → resp_valid high in t+2.
- Throughput: one issue per cycle while resp_ready = 1.
- Backpressure: with resp_ready held low, at most 2 responses accumulate; issue stops once fifo_count + p1_valid = 2.
- Restart: resume issuing in the same cycle resp_ready goes high, because pop is counted in occ_next.
- Fairness: a continuously requesting client waits at most NUM_REQ−1 issues before its grant.
- Contract: resp_valid and the head data must not change while resp_valid = 1 and resp_ready = 0.

## Test plan
Bench ROM model: 1-cycle registered read; addr 2 holds 1, all other addresses 0; WIDTH=1, NUM_REQ=4.

- Single read: requester 1 sends addr 2 at t, resp_ready=1 → req_ready=4'b0010 at t, rom_rd=1 and rom_idx=2 at t, resp_valid/id/data = 1/1/1 at t+2.
- Contention: all 4 request addr 3 from rr_ptr=0 → grants 0,1,2,3 on consecutive cycles, resp_id 0,1,2,3 on t+2..t+5, data 0.
- Round-robin resume: after a grant to 2, requesters 0 and 3 both pending → 3 granted first, then 0.
- Backpressure: resp_ready=0 with 4 pending → exactly 2 issues, FIFO full, req_ready stays 0; raise resp_ready → pop and issue in the same cycle, and 4 responses arrive in order with none lost or duplicated.
- Full throughput: requester 0 streams addrs 0,1,2,3 with resp_ready=1 → 4 consecutive issues, data 0,0,1,0 on t+2..t+5.
- Reset mid-operation: assert rst one cycle after an issue → resp_valid stays 0, FIFO empty, rr_ptr=0; a post-reset request to addr 2 returns data 1 after 2 cycles.
